// File: rtl/life_gen_sequencer_if.sv
// Bundle of the control, load and display signals of the Game-of-Life
// generation sequencer. The master side drives the controls and display
// address. The slave side (the sequencer) returns cell data and status.
interface life_gen_sequencer_if #(
    parameter int GRID_W = 16,
    parameter int GRID_H = 16
);
    localparam int ROW_W = $clog2(GRID_H);
    localparam int COL_W = $clog2(GRID_W);

    logic              frame_tick;
    logic              vblank;
    logic              pause;
    logic              step;
    logic              load_en;
    logic [ROW_W-1:0]  load_row;
    logic [GRID_W-1:0] load_data;
    logic [ROW_W-1:0]  disp_row;
    logic [COL_W-1:0]  disp_col;
    logic              disp_cell;
    logic              load_ready;
    logic              busy;
    logic              gen_done;
    logic [15:0]       gen_count;

    modport master (
        output frame_tick, vblank, pause, step, load_en, load_row, load_data,
               disp_row, disp_col,
        input  disp_cell, load_ready, busy, gen_done, gen_count
    );

    modport slave (
        input  frame_tick, vblank, pause, step, load_en, load_row, load_data,
               disp_row, disp_col,
        output disp_cell, load_ready, busy, gen_done, gen_count
    );
endinterface

// File: rtl/life_gen_sequencer.sv
// Game-of-Life grid owner and generation sequencer.
// The grid is double-buffered. The front plane feeds the pixel path, and the
// next generation is built row by row in the back plane. The planes swap
// only during vertical blanking, so a frame never shows a half-updated grid.
module life_gen_sequencer #(
    parameter int GRID_W         = 16,
    parameter int GRID_H         = 16,
    parameter int FRAMES_PER_GEN = 60
) (
    input logic                 clk,
    input logic                 rst_n,
    life_gen_sequencer_if.slave bus
);
    localparam int ROW_W = $clog2(GRID_H);
    localparam int CNT_W = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_GEN - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(GRID_H - 1);

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        SWAP_WAIT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  frame_cnt;
    logic [CNT_W-1:0]  frame_cnt_nxt;
    logic [ROW_W-1:0]  row_cnt;
    logic              front_sel;
    logic              back_sel;
    logic [GRID_W-1:0] plane [2][GRID_H];
    logic [15:0]       gen_count_q;
    logic              gen_done_q;
    logic              load_we;
    logic              compute_we;
    logic              swap;
    logic [GRID_W-1:0] row_above;
    logic [GRID_W-1:0] row_mid;
    logic [GRID_W-1:0] row_below;
    logic [GRID_W-1:0] new_row;

    // B3/S23 applied to one row. The rows and columns just outside the grid are padded with dead cells.
    function automatic logic [GRID_W-1:0] next_row(
        input logic [GRID_W-1:0] above,
        input logic [GRID_W-1:0] mid,
        input logic [GRID_W-1:0] below
    );
        logic [GRID_W+1:0] a;
        logic [GRID_W+1:0] m;
        logic [GRID_W+1:0] b;
        logic [3:0]        n;
        logic [GRID_W-1:0] res;
        a   = {1'b0, above, 1'b0};
        m   = {1'b0, mid, 1'b0};
        b   = {1'b0, below, 1'b0};
        res = '0;
        for (int c = 0; c < GRID_W; c++) begin
            n = 4'(a[c]) + 4'(a[c+1]) + 4'(a[c+2])
              + 4'(m[c])              + 4'(m[c+2])
              + 4'(b[c]) + 4'(b[c+1]) + 4'(b[c+2]);
            res[c] = (n == 4'd3) || (mid[c] && (n == 4'd2));
        end
        return res;
    endfunction

    assign back_sel = ~front_sel;

    // Fetch the front-plane rows around the row being computed. Rows outside the grid read as dead.
    always_comb begin
        row_above = '0;
        row_below = '0;
        row_mid   = plane[front_sel][row_cnt];
        if (row_cnt != '0) begin
            row_above = plane[front_sel][row_cnt - ROW_W'(1)];
        end
        if (row_cnt != ROW_LAST) begin
            row_below = plane[front_sel][row_cnt + ROW_W'(1)];
        end
    end

    assign new_row = next_row(row_above, row_mid, row_below);

    // State register for the sequencer FSM and the frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            frame_cnt <= '0;
        end else begin
            state     <= state_nxt;
            frame_cnt <= frame_cnt_nxt;
        end
    end

    // Next-state logic. In IDLE, a load takes priority over a start, and the deferred start waits at a saturated frame count.
    always_comb begin
        state_nxt     = state;
        frame_cnt_nxt = frame_cnt;
        load_we       = 1'b0;
        compute_we    = 1'b0;
        swap          = 1'b0;
        case (state)
            IDLE: begin
                load_we = bus.load_en;
                if (bus.frame_tick && !bus.pause) begin
                    if (frame_cnt == CNT_LAST) begin
                        if (!bus.load_en) begin
                            frame_cnt_nxt = '0;
                            state_nxt     = COMPUTE;
                        end
                    end else begin
                        frame_cnt_nxt = frame_cnt + CNT_W'(1);
                    end
                end else if (bus.step && bus.pause && !bus.load_en) begin
                    state_nxt = COMPUTE;
                end
            end
            COMPUTE: begin
                compute_we = 1'b1;
                if (row_cnt == ROW_LAST) begin
                    state_nxt = SWAP_WAIT;
                end
            end
            SWAP_WAIT: begin
                if (bus.vblank) begin
                    swap      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Grid planes, row counter, plane select and generation bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                for (int r = 0; r < GRID_H; r++) begin
                    plane[p][r] <= '0;
                end
            end
            row_cnt     <= '0;
            front_sel   <= 1'b0;
            gen_count_q <= '0;
            gen_done_q  <= 1'b0;
        end else begin
            if (load_we) begin
                plane[front_sel][bus.load_row] <= bus.load_data;
            end
            if (compute_we) begin
                plane[back_sel][row_cnt] <= new_row;
                row_cnt                  <= row_cnt + ROW_W'(1);
            end else begin
                row_cnt <= '0;
            end
            if (swap) begin
                front_sel   <= back_sel;
                gen_count_q <= gen_count_q + 16'd1;
            end
            gen_done_q <= swap;
        end
    end

    assign bus.disp_cell  = plane[front_sel][bus.disp_row][bus.disp_col];
    assign bus.load_ready = (state == IDLE);
    assign bus.busy       = (state != IDLE);
    assign bus.gen_done   = gen_done_q;
    assign bus.gen_count  = gen_count_q;
endmodule

// File: tb/tb_life_gen_sequencer.sv
// Self-checking bench for life_gen_sequencer.
// An independent Game-of-Life model predicts each generation when the bench
// triggers it. The predicted grid and count are queued, then popped and
// compared against the display port when gen_done fires.
module tb_life_gen_sequencer;
    localparam int GW  = 16;
    localparam int GH  = 16;
    localparam int FPG = 2;

    typedef logic [GW*GH-1:0] grid_t;

    logic clk;
    logic rst_n;

    life_gen_sequencer_if #(.GRID_W(GW), .GRID_H(GH)) bus ();

    life_gen_sequencer #(
        .GRID_W(GW),
        .GRID_H(GH),
        .FRAMES_PER_GEN(FPG)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int          compare_count;
    int          fail_count;
    grid_t       model_grid;
    logic [15:0] model_count;
    grid_t       exp_q [$];
    logic [15:0] cnt_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compare_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference B3/S23 step that counts neighbours cell by cell, with explicit bounds checks.
    function automatic grid_t lifeStep(input grid_t g);
        grid_t nxt;
        int    cnt;
        int    rr;
        int    cc;
        nxt = '0;
        for (int r = 0; r < GH; r++) begin
            for (int c = 0; c < GW; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if (!(dr == 0 && dc == 0) && rr >= 0 && rr < GH && cc >= 0 && cc < GW) begin
                            if (g[rr*GW+cc]) cnt++;
                        end
                    end
                end
                if (g[r*GW+c]) nxt[r*GW+c] = (cnt == 2 || cnt == 3);
                else           nxt[r*GW+c] = (cnt == 3);
            end
        end
        return nxt;
    endfunction

    // Read the whole front plane through the display port and compare it row by row with the model.
    task automatic checkGrid(input string tag);
        logic [GW-1:0] row_word;
        for (int r = 0; r < GH; r++) begin
            row_word = '0;
            for (int c = 0; c < GW; c++) begin
                bus.disp_row = 4'(r);
                bus.disp_col = 4'(c);
                #1;
                row_word[c] = bus.disp_cell;
            end
            checkOutput($sformatf("%s_row%0d", tag, r), 32'(row_word), 32'(model_grid[r*GW +: GW]));
        end
    endtask

    // Drive one cycle of tick, step or load. Optionally queue the generation this cycle is expected to start.
    task automatic applyStimulus(input logic tick, input logic stp, input logic ld,
                                 input logic [3:0] lrow, input logic [GW-1:0] ldata, input logic push);
        bus.frame_tick = tick;
        bus.step       = stp;
        bus.load_en    = ld;
        bus.load_row   = lrow;
        bus.load_data  = ldata;
        if (push) begin
            exp_q.push_back(lifeStep(model_grid));
            cnt_q.push_back(model_count + 16'd1);
        end
        @(posedge clk);
        #1;
        bus.frame_tick = 1'b0;
        bus.step       = 1'b0;
        bus.load_en    = 1'b0;
    endtask

    task automatic loadRow(input logic [3:0] r, input logic [GW-1:0] d);
        applyStimulus(1'b0, 1'b0, 1'b1, r, d, 1'b0);
        model_grid[r*GW +: GW] = d;
    endtask

    // Wait for gen_done within a cycle budget, then pop the prediction and check count and grid.
    task automatic waitGenDone(input logic chk_busy, input int exp_busy);
        int   busy_cycles;
        logic seen;
        busy_cycles = bus.busy ? 1 : 0;
        seen        = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (bus.gen_done) seen = 1'b1;
            else if (bus.busy) busy_cycles++;
        end
        checkOutput("gen_done_seen", 32'(seen), 32'd1);
        if (chk_busy) checkOutput("busy_cycles", 32'(busy_cycles), 32'(exp_busy));
        @(posedge clk);
        #1;
        checkOutput("gen_done_single", 32'(bus.gen_done), 32'd0);
        checkOutput("busy_after_swap", 32'(bus.busy), 32'd0);
        if (exp_q.size() > 0) begin
            model_grid  = exp_q.pop_front();
            model_count = cnt_q.pop_front();
        end
        checkOutput("gen_count", 32'(bus.gen_count), 32'(model_count));
        checkGrid("grid");
    endtask

    // Main sequence of scenarios.
    initial begin
        int   busy_seen;
        int   done_seen;
        compare_count  = 0;
        fail_count     = 0;
        model_grid     = '0;
        model_count    = '0;
        rst_n          = 1'b0;
        bus.frame_tick = 1'b0;
        bus.vblank     = 1'b1;
        bus.pause      = 1'b0;
        bus.step       = 1'b0;
        bus.load_en    = 1'b0;
        bus.load_row   = '0;
        bus.load_data  = '0;
        bus.disp_row   = '0;
        bus.disp_col   = '0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_load_ready", 32'(bus.load_ready), 32'd1);
        checkOutput("rst_gen_done", 32'(bus.gen_done), 32'd0);
        checkOutput("rst_gen_count", 32'(bus.gen_count), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkGrid("rst");

        $display("[TB] blinker");
        loadRow(4'd7, 16'h0100);
        loadRow(4'd8, 16'h0100);
        loadRow(4'd9, 16'h0100);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, '0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, '0, 1'b1);
        // COMPUTE takes GH cycles and SWAP_WAIT takes one more cycle, with vblank already high.
        waitGenDone(1'b1, GH + 1);

        $display("[TB] corner block, lone edge cell, edge birth");
        for (int r = 0; r < GH; r++) begin
            loadRow(4'(r), (r == 0) ? 16'h8003 : (r == 1) ? 16'h0003 : (r == 15) ? 16'h0007 : 16'h0000);
        end
        for (int g = 0; g < 3; g++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, '0, 1'b0);
            applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, '0, 1'b1);
            waitGenDone(1'b1, GH + 1);
        end
        checkOutput("block_row0", 32'(model_grid[0 +: GW]), 32'h0003);

        $display("[TB] pause and step");
        bus.pause = 1'b1;
        busy_seen = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, '0, 1'b0);
            if (bus.busy) busy_seen++;
        end
        checkOutput("paused_busy", 32'(busy_seen), 32'd0);
        checkOutput("paused_gen_count", 32'(bus.gen_count), 32'(model_count));
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, '0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, '0, 1'b0);
        waitGenDone(1'b0, 0);
        busy_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (bus.busy) busy_seen++;
        end
        checkOutput("no_second_gen", 32'(busy_seen), 32'd0);
        checkOutput("step_gen_count", 32'(bus.gen_count), 32'(model_count));

        $display("[TB] vblank held low");
        bus.vblank = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, '0, 1'b1);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.gen_done) done_seen++;
        end
        checkOutput("hold_busy", 32'(bus.busy), 32'd1);
        checkOutput("hold_no_done", 32'(done_seen), 32'd0);
        checkGrid("hold");
        bus.vblank = 1'b1;
        waitGenDone(1'b0, 0);

        $display("[TB] load during compute");
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, '0, 1'b1);
        bus.load_en   = 1'b1;
        bus.load_row  = 4'd5;
        bus.load_data = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            checkOutput("busy_load_ready", 32'(bus.load_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        bus.load_en = 1'b0;
        waitGenDone(1'b0, 0);

        $display("[TB] load wins over start");
        bus.pause = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, '0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd3, 16'h0038, 1'b0);
        model_grid[3*GW +: GW] = 16'h0038;
        busy_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (bus.busy) busy_seen++;
        end
        checkOutput("load_blocks_start", 32'(busy_seen), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, '0, 1'b1);
        waitGenDone(1'b1, GH + 1);

        $display("[TB] reset mid compute");
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, '0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, '0, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        checkOutput("pre_reset_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("mid_rst_load_ready", 32'(bus.load_ready), 32'd1);
        checkOutput("mid_rst_gen_done", 32'(bus.gen_done), 32'd0);
        checkOutput("mid_rst_gen_count", 32'(bus.gen_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        model_grid  = '0;
        model_count = '0;
        exp_q.delete();
        cnt_q.delete();
        checkGrid("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end
endmodule
